// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch handshake between the fetch stage and instruction memory.
interface pc_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, fetch FSM, one-entry stall buffer and IF/ID register.
// PC+4 comes from an external adder fed by pc_out/pc_inc.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic               clk,
    input  logic               reset,
    pc_fetch_unit_if.master    imem,
    output logic [31:0]        pc_out,
    output logic [31:0]        pc_inc,
    input  logic [31:0]        pc_plus4_in,
    input  logic               stall,
    input  logic               flush,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic               jump,
    input  logic [31:0]        jump_target,
    output logic               if_id_valid,
    output logic [31:0]        if_id_instr,
    output logic [31:0]        if_id_pc_plus4
);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

    state_t      state, state_d;
    logic [31:0] pc, pc_d;
    logic        redir_pend, redir_pend_d;
    logic [31:0] pend_tgt, pend_tgt_d;
    logic [31:0] buf_instr, buf_instr_d;
    logic [31:0] buf_pc4, buf_pc4_d;
    logic        vld_d;
    logic [31:0] instr_d, pc4_d;

    logic        redir;
    logic [31:0] redir_tgt;

    // Branch wins over jump; targets are word-aligned by clearing the low bits.
    assign redir     = branch_taken | jump;
    assign redir_tgt = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;

    assign pc_out         = pc;
    assign pc_inc         = PC_INC;
    assign imem.imem_addr = pc;

    // Next-state and next-value logic for the FSM, PC, buffer and IF/ID.
    always_comb begin
        state_d       = state;
        pc_d          = pc;
        redir_pend_d  = redir_pend;
        pend_tgt_d    = pend_tgt;
        buf_instr_d   = buf_instr;
        buf_pc4_d     = buf_pc4;
        vld_d         = if_id_valid;
        instr_d       = if_id_instr;
        pc4_d         = if_id_pc_plus4;
        imem.imem_req = 1'b0;

        case (state)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem.imem_req = 1'b1;
                if (!imem.imem_ready) begin
                    // Remember a redirect that lands while the fetch is outstanding;
                    // the newest one wins. Address must stay stable, so pc holds.
                    if (redir) begin
                        redir_pend_d = 1'b1;
                        pend_tgt_d   = redir_tgt;
                    end
                    if (!stall) vld_d = 1'b0;
                end else if (redir || redir_pend) begin
                    // Fetched word belongs to the wrong path: drop it and steer.
                    pc_d         = redir ? redir_tgt : pend_tgt;
                    redir_pend_d = 1'b0;
                    if (!stall) vld_d = 1'b0;
                end else if (stall) begin
                    // Memory already returned data; park it until the stall clears.
                    buf_instr_d = imem.imem_rdata;
                    buf_pc4_d   = pc_plus4_in;
                    pc_d        = pc_plus4_in;
                    state_d     = HOLD;
                end else begin
                    instr_d = imem.imem_rdata;
                    pc4_d   = pc_plus4_in;
                    vld_d   = 1'b1;
                    pc_d    = pc_plus4_in;
                end
            end
            HOLD: begin
                if (redir) begin
                    pc_d    = redir_tgt;
                    state_d = FETCH;
                    if (!stall) vld_d = 1'b0;
                end else if (!stall) begin
                    instr_d = buf_instr;
                    pc4_d   = buf_pc4;
                    vld_d   = 1'b1;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        // Flush kills the IF/ID entry regardless of stall or a pending load.
        if (flush) vld_d = 1'b0;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= BOOT;
            pc             <= RESET_PC;
            redir_pend     <= 1'b0;
            pend_tgt       <= 32'h0;
            buf_instr      <= 32'h0;
            buf_pc4        <= 32'h0;
            if_id_valid    <= 1'b0;
            if_id_instr    <= 32'h0;
            if_id_pc_plus4 <= 32'h0;
        end else begin
            state          <= state_d;
            pc             <= pc_d;
            redir_pend     <= redir_pend_d;
            pend_tgt       <= pend_tgt_d;
            buf_instr      <= buf_instr_d;
            buf_pc4        <= buf_pc4_d;
            if_id_valid    <= vld_d;
            if_id_instr    <= instr_d;
            if_id_pc_plus4 <= pc4_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed test of pc_fetch_unit with an external PC adder and an address-echo memory.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_out, pc_inc, pc_plus4;
    logic        stall, flush, branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic        if_id_valid;
    logic [31:0] if_id_instr, if_id_pc_plus4;
    logic        ready;

    int errs   = 0;
    int checks = 0;

    pc_fetch_unit_if imem_if ();

    pc_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem           (imem_if),
        .pc_out         (pc_out),
        .pc_inc         (pc_inc),
        .pc_plus4_in    (pc_plus4),
        .stall          (stall),
        .flush          (flush),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4)
    );

    // External 32-bit adder and a memory whose word is 0x2001_0000 | addr[15:0].
    assign pc_plus4           = pc_out + pc_inc;
    assign imem_if.imem_ready = ready;
    assign imem_if.imem_rdata = 32'h2001_0000 | {16'h0, imem_if.imem_addr[15:0]};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the full visible state in one call.
    task automatic chk_all(input string tag, input logic [31:0] pc, input logic req,
                           input logic vld, input logic [31:0] instr, input logic [31:0] pc4);
        chk({tag, ".pc"},    pc_out, pc);
        chk({tag, ".addr"},  imem_if.imem_addr, pc);
        chk({tag, ".req"},   {31'h0, imem_if.imem_req}, {31'h0, req});
        chk({tag, ".vld"},   {31'h0, if_id_valid}, {31'h0, vld});
        chk({tag, ".instr"}, if_id_instr, instr);
        chk({tag, ".pc4"},   if_id_pc_plus4, pc4);
    endtask

    initial begin
        reset = 1'b1; ready = 1'b0; stall = 1'b0; flush = 1'b0;
        branch_taken = 1'b0; jump = 1'b0; branch_target = '0; jump_target = '0;
        tick(); tick();
        chk_all("rst", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("pc_inc", pc_inc, 32'd4);

        // 1: sequential fetch with ready held high
        reset = 1'b0; ready = 1'b1;
        tick();
        chk_all("boot", 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        chk_all("seq0", 32'h4, 1'b1, 1'b1, 32'h2001_0000, 32'h4);
        tick();
        chk_all("seq1", 32'h8, 1'b1, 1'b1, 32'h2001_0004, 32'h8);

        // 2: memory wait states at pc=8
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("wait", 32'h8, 1'b1, 1'b0, 32'h2001_0004, 32'h8);
        end
        ready = 1'b1;
        tick();
        chk_all("wdone", 32'hC, 1'b1, 1'b1, 32'h2001_0008, 32'hC);

        // 3: branch arriving mid-fetch is held until ready, data discarded
        ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
        tick();
        chk_all("bpend", 32'hC, 1'b1, 1'b0, 32'h2001_0008, 32'hC);
        branch_taken = 1'b0;
        tick();
        chk_all("bhold", 32'hC, 1'b1, 1'b0, 32'h2001_0008, 32'hC);
        ready = 1'b1;
        tick();
        chk_all("bdisc", 32'h40, 1'b1, 1'b0, 32'h2001_0008, 32'hC);
        tick();
        chk_all("bfet", 32'h44, 1'b1, 1'b1, 32'h2001_0040, 32'h44);
        branch_taken = 1'b1; branch_target = 32'h43;
        tick();
        chk_all("balign", 32'h40, 1'b1, 1'b0, 32'h2001_0040, 32'h44);

        // 4: branch beats jump
        branch_target = 32'h100; jump = 1'b1; jump_target = 32'h200;
        tick();
        chk("bprio", pc_out, 32'h100);
        branch_taken = 1'b0; jump = 1'b0;
        tick();
        chk_all("bpfet", 32'h104, 1'b1, 1'b1, 32'h2001_0100, 32'h104);

        // 5: stall during fetch buffers the word
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all("stall", 32'h108, 1'b0, 1'b1, 32'h2001_0100, 32'h104);
        end
        stall = 1'b0;
        tick();
        chk_all("unbuf", 32'h108, 1'b1, 1'b1, 32'h2001_0104, 32'h108);
        tick();
        chk_all("resume", 32'h10C, 1'b1, 1'b1, 32'h2001_0108, 32'h10C);

        // 6: flush overrides stall; reset mid-wait
        stall = 1'b1; flush = 1'b1; ready = 1'b0;
        tick();
        chk_all("flush", 32'h10C, 1'b1, 1'b0, 32'h2001_0108, 32'h10C);
        stall = 1'b0; flush = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk_all("rstmid", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0; ready = 1'b1;
        tick();

        // PC wrap via jump to the last word
        jump = 1'b1; jump_target = 32'hFFFF_FFFE;
        tick();
        chk("jtop", pc_out, 32'hFFFF_FFFC);
        jump = 1'b0;
        tick();
        chk_all("wrap", 32'h0, 1'b1, 1'b1, 32'h2001_FFFC, 32'h0);

        // Redirect while holding a buffered word, stall still asserted
        stall = 1'b1;
        tick();
        chk_all("hold", 32'h4, 1'b0, 1'b1, 32'h2001_FFFC, 32'h0);
        branch_taken = 1'b1; branch_target = 32'h80;
        tick();
        chk_all("hredir", 32'h80, 1'b1, 1'b1, 32'h2001_FFFC, 32'h0);
        branch_taken = 1'b0; stall = 1'b0;
        tick();
        chk_all("hfet", 32'h84, 1'b1, 1'b1, 32'h2001_0080, 32'h84);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
